frac_divider: RTL and testbench

FRAC_DIVIDER -- requirements
Module: frac_divider

---
 rtl/frac_divider_if.sv | 29 ++
 rtl/frac_divider.sv | 109 ++++++++++
 tb/tb_frac_divider.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/frac_divider_if.sv
// Operand/result handshake bundle for frac_divider.
// The requester drives operands and out_ready; the divider drives the rest.
interface frac_divider_if #(
    parameter int unsigned DW_A = 10,
    parameter int unsigned DW_B = 3,
    parameter int unsigned FRAC = 10
);
    localparam int unsigned QW = DW_A + FRAC;

    logic            in_valid;
    logic            in_ready;
    logic [DW_A-1:0] in_a;
    logic [DW_B-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [QW-1:0]   out_q;
    logic [DW_B-1:0] out_r;
    logic            out_dz;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_q, out_r, out_dz
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_q, out_r, out_dz
    );
endinterface

// File: rtl/frac_divider.sv
// Fixed-point restoring divider: q = floor(a*2^FRAC / b), one quotient bit per cycle.
// Divide-by-zero skips the iteration and returns an all-ones quotient with a flag.
module frac_divider #(
    parameter int unsigned DW_A = 10,
    parameter int unsigned DW_B = 3,
    parameter int unsigned FRAC = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    frac_divider_if.slave bus
);
    localparam int unsigned QW = DW_A + FRAC;
    localparam int unsigned CW = $clog2(QW + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q, state_d;
    logic [QW-1:0]   num_q, num_d;
    logic [QW-1:0]   quo_q, quo_d;
    logic [DW_B-1:0] div_q, div_d;
    logic [DW_B:0]   rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            dz_q, dz_d;

    logic            accept;
    logic            deliver;
    logic [DW_B+1:0] rem_shift;
    logic            bit_set;

    assign accept    = bus.in_valid && (state_q == StIdle);
    assign deliver   = bus.out_ready && (state_q == StDone);

    // One extra bit of headroom so 2r+1 never wraps before the compare.
    assign rem_shift = {rem_q, num_q[QW-1]};
    assign bit_set   = rem_shift >= (DW_B + 2)'(div_q);

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        quo_d   = quo_q;
        div_d   = div_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (bus.in_b == '0) begin
                        state_d = StDone;
                        quo_d   = '1;
                        rem_d   = '0;
                        dz_d    = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = StCalc;
                        num_d   = QW'(bus.in_a) << FRAC;
                        div_d   = bus.in_b;
                        quo_d   = '0;
                        rem_d   = '0;
                        dz_d    = 1'b0;
                        cnt_d   = CW'(QW);
                    end
                end
            end
            StCalc: begin
                num_d = num_q << 1;
                quo_d = (quo_q << 1) | QW'(bit_set);
                rem_d = bit_set ? (DW_B + 1)'(rem_shift - (DW_B + 2)'(div_q))
                                : rem_shift[DW_B:0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (deliver) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            num_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.out_q     = quo_q;
    assign bus.out_r     = rem_q[DW_B-1:0];
    assign bus.out_dz    = dz_q;
endmodule

// File: tb/tb_frac_divider.sv
// Randomized bench for frac_divider: default and (16,8,0) parameter sets against an
// arithmetic reference, plus directed backpressure and mid-computation reset cases.
module tb_frac_divider;
    localparam int unsigned DA0 = 10, DB0 = 3, FR0 = 10, QW0 = 20;
    localparam int unsigned DA1 = 16, DB1 = 8, FR1 = 0, QW1 = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    frac_divider_if #(.DW_A(DA0), .DW_B(DB0), .FRAC(FR0)) d_if ();
    frac_divider_if #(.DW_A(DA1), .DW_B(DB1), .FRAC(FR1)) p_if ();

    frac_divider #(.DW_A(DA0), .DW_B(DB0), .FRAC(FR0)) u_dut_d (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (d_if.slave)
    );

    frac_divider #(.DW_A(DA1), .DW_B(DB1), .FRAC(FR1)) u_dut_p (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (p_if.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input bit iv, input longint unsigned a,
                         input longint unsigned b, input bit ordy);
        if (sel) begin
            p_if.in_valid  = iv;
            p_if.in_a      = DA1'(a);
            p_if.in_b      = DB1'(b);
            p_if.out_ready = ordy;
        end else begin
            d_if.in_valid  = iv;
            d_if.in_a      = DA0'(a);
            d_if.in_b      = DB0'(b);
            d_if.out_ready = ordy;
        end
    endtask

    task automatic sample(input bit sel, output logic ov, output logic ir,
                          output logic [63:0] q, output logic [63:0] r, output logic dz);
        if (sel) begin
            ov = p_if.out_valid; ir = p_if.in_ready;
            q = 64'(p_if.out_q); r = 64'(p_if.out_r); dz = p_if.out_dz;
        end else begin
            ov = d_if.out_valid; ir = d_if.in_ready;
            q = 64'(d_if.out_q); r = 64'(d_if.out_r); dz = d_if.out_dz;
        end
    endtask

    // Reference: plain integer division of a*2^FRAC by b.
    task automatic ref_div(input bit sel, input longint unsigned a, input longint unsigned b,
                           output longint unsigned q, output longint unsigned r,
                           output bit dz, output int lat);
        int unsigned fr = sel ? FR1 : FR0;
        int unsigned qw = sel ? QW1 : QW0;
        longint unsigned n = a << fr;
        if (b == 0) begin
            q = (64'd1 << qw) - 1; r = 0; dz = 1'b1; lat = 1;
        end else begin
            q = n / b; r = n % b; dz = 1'b0; lat = int'(qw) + 1;
        end
    endtask

    // Called and returns just after a falling edge.
    task automatic do_op(input bit sel, input longint unsigned a, input longint unsigned b,
                         input int hold, input string tag,
                         output logic [63:0] q_obs, output logic [63:0] r_obs);
        longint unsigned eq, er;
        bit edz;
        int elat, n;
        logic ov, ir, dz, dz_hold;
        logic [63:0] q, r, q_hold, r_hold;

        ref_div(sel, a, b, eq, er, edz, elat);
        sample(sel, ov, ir, q, r, dz);
        check_eq({tag, ".in_ready_before"}, 64'(ir), 64'd1);
        drive(sel, 1'b1, a, b, hold == 0);
        @(posedge clk);
        #1 drive(sel, 1'b0, a, b, hold == 0);
        n = 0;
        @(negedge clk);
        sample(sel, ov, ir, q, r, dz);
        while (!ov && n < 100) begin
            @(negedge clk);
            n++;
            sample(sel, ov, ir, q, r, dz);
        end
        check_eq({tag, ".latency"}, 64'(n + 1), 64'(elat));
        check_eq({tag, ".q"}, q, eq);
        check_eq({tag, ".r"}, r, er);
        check_eq({tag, ".dz"}, 64'(dz), 64'(edz));
        q_hold = q; r_hold = r; dz_hold = dz;
        for (int h = 0; h < hold; h++) begin
            drive(sel, 1'b1, $urandom, $urandom, 1'b0);
            @(negedge clk);
            sample(sel, ov, ir, q, r, dz);
            check_eq({tag, ".hold_valid"}, 64'(ov), 64'd1);
            check_eq({tag, ".hold_in_ready"}, 64'(ir), 64'd0);
            check_eq({tag, ".hold_q"}, q, q_hold);
            check_eq({tag, ".hold_r"}, r, r_hold);
            check_eq({tag, ".hold_dz"}, 64'(dz), 64'(dz_hold));
        end
        drive(sel, 1'b0, 0, 0, 1'b1);
        @(negedge clk);
        sample(sel, ov, ir, q, r, dz);
        check_eq({tag, ".after_valid"}, 64'(ov), 64'd0);
        check_eq({tag, ".after_in_ready"}, 64'(ir), 64'd1);
        check_eq({tag, ".retain_q"}, q, q_hold);
        q_obs = q_hold;
        r_obs = r_hold;
    endtask

    initial begin
        logic ov, ir, dz;
        logic [63:0] q, r, qo, ro;
        int nv;

        drive(1'b0, 1'b0, 0, 0, 1'b1);
        drive(1'b1, 1'b0, 0, 0, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sample(s[0], ov, ir, q, r, dz);
            check_eq("reset.out_valid", 64'(ov), 64'd0);
            check_eq("reset.in_ready", 64'(ir), 64'd1);
            check_eq("reset.q", q, 64'd0);
            check_eq("reset.r", r, 64'd0);
            check_eq("reset.dz", 64'(dz), 64'd0);
        end

        do_op(1'b0, 1, 3, 0, "a1_b3", qo, ro);
        check_eq("a1_b3.q_const", qo, 64'h155);
        check_eq("a1_b3.r_const", ro, 64'd1);
        do_op(1'b0, 1023, 1, 0, "a1023_b1", qo, ro);
        check_eq("a1023_b1.q_const", qo, 64'hFFC00);
        do_op(1'b0, 1023, 7, 0, "a1023_b7", qo, ro);
        check_eq("a1023_b7.q_const", qo, 64'h24892);
        check_eq("a1023_b7.r_const", ro, 64'd2);
        do_op(1'b0, 5, 0, 0, "div_zero", qo, ro);
        check_eq("div_zero.q_const", qo, 64'hFFFFF);
        do_op(1'b0, 700, 5, 5, "backpressure", qo, ro);

        // Reset pulse in the middle of an iteration must discard the result.
        drive(1'b0, 1'b1, 9, 5, 1'b1);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 0, 0, 1'b1);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        sample(1'b0, ov, ir, q, r, dz);
        check_eq("midrst.out_valid", 64'(ov), 64'd0);
        check_eq("midrst.in_ready", 64'(ir), 64'd1);
        check_eq("midrst.q", q, 64'd0);
        check_eq("midrst.r", r, 64'd0);
        check_eq("midrst.dz", 64'(dz), 64'd0);
        rst_n = 1'b1;
        nv = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            sample(1'b0, ov, ir, q, r, dz);
            nv += int'(ov);
        end
        check_eq("midrst.no_valid", 64'(nv), 64'd0);
        do_op(1'b0, 6, 4, 0, "post_rst", qo, ro);
        check_eq("post_rst.q_const", qo, 64'h600);
        check_eq("post_rst.r_const", ro, 64'd0);

        for (int i = 0; i < 60; i++) begin
            do_op(1'b0, $urandom_range(1023, 0), $urandom_range(7, 0),
                  int'($urandom_range(3, 0)), "rand_def", qo, ro);
        end
        for (int i = 0; i < 1000; i++) begin
            do_op(1'b1, $urandom_range(65535, 0), $urandom_range(255, 0), 0,
                  "rand_p16", qo, ro);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
